// File: rtl/router_sync_if.sv
// Handshake bundle between the router FSM/clients/FIFOs and router_sync.
interface router_sync_if;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       addr_err;

  modport master (
    output detect_add, data_in, write_enb_reg,
    output read_enb_0, read_enb_1, read_enb_2,
    output empty_0, empty_1, empty_2,
    output full_0, full_1, full_2,
    input  write_enb, fifo_full, addr_err,
    input  vld_out_0, vld_out_1, vld_out_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2
  );

  modport slave (
    input  detect_add, data_in, write_enb_reg,
    input  read_enb_0, read_enb_1, read_enb_2,
    input  empty_0, empty_1, empty_2,
    input  full_0, full_1, full_2,
    output write_enb, fifo_full, addr_err,
    output vld_out_0, vld_out_1, vld_out_2,
    output soft_reset_0, soft_reset_1, soft_reset_2
  );
endinterface

// File: rtl/router_sync.sv
// Address latch, write-strobe steering, full-flag mux and per-port unread-data
// watchdogs for the three output FIFOs of the 1x3 router.
module router_sync_wd #(
  parameter int TIMEOUT = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);
  localparam logic [5:0] LAST = 6'(TIMEOUT - 1);

  logic [5:0] cnt;
  logic       idle;

  // A pulse itself counts as activity, so two pulses can never be adjacent.
  assign idle = vld & ~rd & ~soft_reset;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (!idle) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (cnt == LAST) begin
      cnt        <= '0;
      soft_reset <= 1'b1;
    end else begin
      cnt        <= cnt + 6'd1;
      soft_reset <= 1'b0;
    end
  end
endmodule

module router_sync #(
  parameter int TIMEOUT = 30
) (
  input  logic           clk,
  input  logic           rst,
  router_sync_if.slave   bus
);
  localparam int NUM_PORTS = 3;

  logic [1:0]           addr;
  logic                 addr_err_q;
  logic [NUM_PORTS-1:0] empty, full, rd, vld, sr;
  logic [NUM_PORTS-1:0] write_enb;
  logic                 fifo_full;

  assign empty = {bus.empty_2, bus.empty_1, bus.empty_0};
  assign full  = {bus.full_2, bus.full_1, bus.full_0};
  assign rd    = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};
  assign vld   = ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr       <= 2'b11;
      addr_err_q <= 1'b0;
    end else if (bus.detect_add) begin
      addr       <= bus.data_in;
      addr_err_q <= (bus.data_in == 2'd3);
    end
  end

  // Address 3 selects nothing: no write, no full back-pressure.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    case (addr)
      2'd0: begin write_enb[0] = bus.write_enb_reg; fifo_full = full[0]; end
      2'd1: begin write_enb[1] = bus.write_enb_reg; fifo_full = full[1]; end
      2'd2: begin write_enb[2] = bus.write_enb_reg; fifo_full = full[2]; end
      default: ;
    endcase
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_wd
    router_sync_wd #(.TIMEOUT(TIMEOUT)) u_wd (
      .clk        (clk),
      .rst        (rst),
      .vld        (vld[g]),
      .rd         (rd[g]),
      .soft_reset (sr[g])
    );
  end

  assign bus.write_enb    = write_enb;
  assign bus.fifo_full    = fifo_full;
  assign bus.addr_err     = addr_err_q;
  assign bus.vld_out_0    = vld[0];
  assign bus.vld_out_1    = vld[1];
  assign bus.vld_out_2    = vld[2];
  assign bus.soft_reset_0 = sr[0];
  assign bus.soft_reset_1 = sr[1];
  assign bus.soft_reset_2 = sr[2];
endmodule

// File: tb/tb_router_sync.sv
// Scoreboard bench for router_sync: expected output vectors are queued as
// stimulus is applied and compared when the DUT output is sampled.
module tb_router_sync;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  router_sync_if bus();
  router_sync #(.TIMEOUT(30)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [2:0] empty, full, rd;
  assign bus.empty_0    = empty[0];
  assign bus.empty_1    = empty[1];
  assign bus.empty_2    = empty[2];
  assign bus.full_0     = full[0];
  assign bus.full_1     = full[1];
  assign bus.full_2     = full[2];
  assign bus.read_enb_0 = rd[0];
  assign bus.read_enb_1 = rd[1];
  assign bus.read_enb_2 = rd[2];

  int n_tests = 0;
  int n_fail  = 0;
  logic [10:0] sb[$];

  // {vld_out[2:0], addr_err, fifo_full, write_enb[2:0], soft_reset[2:0]}
  function automatic logic [10:0] obs();
    return {bus.vld_out_2, bus.vld_out_1, bus.vld_out_0, bus.addr_err, bus.fifo_full,
            bus.write_enb, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
  endfunction

  function automatic logic [10:0] mk(input logic [2:0] e, input logic aerr, input logic ff,
                                     input logic [2:0] we, input logic [2:0] sr);
    return {~e, aerr, ff, we, sr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.detect_add = 1'b0; bus.data_in = 2'd0; bus.write_enb_reg = 1'b0;
    empty = 3'b111; full = 3'b000; rd = 3'b000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] got, want;
    empty = 3'b111; full = 3'b000; rd = 3'b000;
    rst = 1'b1; bus.detect_add = 1'b1; bus.data_in = 2'd1; bus.write_enb_reg = 1'b1;
    sb.push_back(mk(3'b111, 1'b0, 1'b0, 3'b000, 3'b000));
    tick();
    got = obs(); want = sb.pop_front(); n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL reset_state: got %b want %b", got, want); end
    rst = 1'b0; bus.detect_add = 1'b0; empty = 3'b101;
    sb.push_back(mk(3'b101, 1'b0, 1'b0, 3'b000, 3'b000));
    #1;
    got = obs(); want = sb.pop_front(); n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL reset_vld: got %b want %b", got, want); end
    bus.write_enb_reg = 1'b0; empty = 3'b111;
  endtask

  task automatic test_addr_write();
    logic [10:0] got, want;
    do_reset();
    bus.detect_add = 1'b1; bus.data_in = 2'd1; bus.write_enb_reg = 1'b0;
    sb.push_back(mk(3'b111, 1'b0, 1'b0, 3'b000, 3'b000));
    #1;
    got = obs(); want = sb.pop_front(); n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL we_pre_latch: got %b want %b", got, want); end
    tick();
    bus.detect_add = 1'b0; bus.write_enb_reg = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(3'b111, 1'b0, 1'b0, 3'b010, 3'b000));
      #1;
      got = obs(); want = sb.pop_front(); n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL we_port1[%0d]: got %b want %b", i, got, want); end
      tick();
    end
    // Write in the detect cycle still targets the previously latched port.
    bus.detect_add = 1'b1; bus.data_in = 2'd2;
    sb.push_back(mk(3'b111, 1'b0, 1'b0, 3'b010, 3'b000));
    #1;
    got = obs(); want = sb.pop_front(); n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL we_detect_cycle: got %b want %b", got, want); end
    tick();
    bus.detect_add = 1'b0;
    sb.push_back(mk(3'b111, 1'b0, 1'b0, 3'b100, 3'b000));
    #1;
    got = obs(); want = sb.pop_front(); n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL we_retarget: got %b want %b", got, want); end
    bus.write_enb_reg = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic [10:0] got, want;
    do_reset();
    full = 3'b100;
    bus.detect_add = 1'b1; bus.data_in = 2'd2;
    tick();
    bus.detect_add = 1'b0;
    sb.push_back(mk(3'b111, 1'b0, 1'b1, 3'b000, 3'b000));
    #1;
    got = obs(); want = sb.pop_front(); n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL ff_port2: got %b want %b", got, want); end
    bus.detect_add = 1'b1; bus.data_in = 2'd0;
    sb.push_back(mk(3'b111, 1'b0, 1'b1, 3'b000, 3'b000));
    #1;
    got = obs(); want = sb.pop_front(); n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL ff_hold: got %b want %b", got, want); end
    tick();
    bus.detect_add = 1'b0;
    sb.push_back(mk(3'b111, 1'b0, 1'b0, 3'b000, 3'b000));
    #1;
    got = obs(); want = sb.pop_front(); n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL ff_port0_clear: got %b want %b", got, want); end
    full = 3'b001;
    sb.push_back(mk(3'b111, 1'b0, 1'b1, 3'b000, 3'b000));
    #1;
    got = obs(); want = sb.pop_front(); n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL ff_port0_full: got %b want %b", got, want); end
    full = 3'b000;
  endtask

  task automatic test_addr_err();
    logic [10:0] got, want;
    do_reset();
    full = 3'b111;
    bus.detect_add = 1'b1; bus.data_in = 2'd3;
    tick();
    bus.detect_add = 1'b0; bus.write_enb_reg = 1'b1;
    sb.push_back(mk(3'b111, 1'b1, 1'b0, 3'b000, 3'b000));
    #1;
    got = obs(); want = sb.pop_front(); n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL addr_err_set: got %b want %b", got, want); end
    bus.detect_add = 1'b1; bus.data_in = 2'd0;
    tick();
    bus.detect_add = 1'b0;
    sb.push_back(mk(3'b111, 1'b0, 1'b1, 3'b001, 3'b000));
    #1;
    got = obs(); want = sb.pop_front(); n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL addr_err_clear: got %b want %b", got, want); end
    bus.write_enb_reg = 1'b0; full = 3'b000;
  endtask

  task automatic test_timeout();
    logic [10:0] got, want;
    do_reset();
    empty = 3'b110;
    for (int k = 1; k <= 31; k++) begin
      sb.push_back(mk(3'b110, 1'b0, 1'b0, 3'b000, (k == 30) ? 3'b001 : 3'b000));
      tick();
      got = obs(); want = sb.pop_front(); n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL timeout_p0 edge %0d: got %b want %b", k, got, want); end
    end
    do_reset();
    empty = 3'b110;
    // Read on edge 29 restarts the count, so the pulse follows edge 59.
    for (int k = 1; k <= 60; k++) begin
      rd = (k == 29) ? 3'b001 : 3'b000;
      sb.push_back(mk(3'b110, 1'b0, 1'b0, 3'b000, (k == 59) ? 3'b001 : 3'b000));
      tick();
      got = obs(); want = sb.pop_front(); n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL read_restart edge %0d: got %b want %b", k, got, want); end
    end
    rd = 3'b000; empty = 3'b111;
  endtask

  task automatic test_two_ports();
    logic [10:0] got, want;
    do_reset();
    empty = 3'b001;
    for (int k = 1; k <= 31; k++) begin
      sb.push_back(mk(3'b001, 1'b0, 1'b0, 3'b000, (k == 30) ? 3'b110 : 3'b000));
      tick();
      got = obs(); want = sb.pop_front(); n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL two_ports edge %0d: got %b want %b", k, got, want); end
    end
    empty = 3'b111;
  endtask

  task automatic test_rst_mid();
    logic [10:0] got, want;
    do_reset();
    empty = 3'b110;
    for (int k = 1; k <= 51; k++) begin
      rst = (k == 20);
      sb.push_back(mk(3'b110, 1'b0, 1'b0, 3'b000, (k == 50) ? 3'b001 : 3'b000));
      tick();
      got = obs(); want = sb.pop_front(); n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL rst_mid edge %0d: got %b want %b", k, got, want); end
    end
    rst = 1'b0; empty = 3'b111;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, tests run %0d", n_tests);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.detect_add = 1'b0; bus.data_in = 2'd0; bus.write_enb_reg = 1'b0;
    empty = 3'b111; full = 3'b000; rd = 3'b000;
    #2;
    test_reset();
    test_addr_write();
    test_fifo_full();
    test_addr_err();
    test_timeout();
    test_two_ports();
    test_rst_mid();
    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/router_sync.md
# router_sync

Synchronizer and controller for the three output FIFOs of the 1x3 router. Latches the destination address of each incoming packet, steers the router FSM's write strobe to the addressed FIFO, and reports that FIFO's full status back to the FSM. It also drives per-port valid flags to the destination clients. A per-port watchdog soft-resets any FIFO whose data sits unread for TIMEOUT cycles.

## Interface
- TIMEOUT, 30, consecutive valid-but-unread cycles before a port's soft reset fires; legal range 2..63.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- detect_add  in  1  FSM strobe: capture data_in as packet destination this cycle.
- data_in  in  2  destination address (0, 1, 2 valid; 3 invalid).
- write_enb_reg  in  1  FSM write strobe for the current packet byte.
- read_enb_0/1/2  in  1 each  client read strobe per port.
- empty_0/1/2  in  1 each  FIFO empty flags.
- full_0/1/2  in  1 each  FIFO full flags.
- write_enb  out  3  one-hot FIFO write enables; bit n drives FIFO n.
- fifo_full  out  1  full flag of the currently addressed FIFO.
- vld_out_0/1/2  out  1 each  port has data (= ~empty_n).
- soft_reset_0/1/2  out  1 each  one-cycle FIFO soft-reset pulse.
- addr_err  out  1  last captured address was 3.

## Operation
- Address register (2 bits): loads data_in on a clock edge with detect_add=1 and holds otherwise. Reset value 2'b11 (no port selected).
- addr_err register: loads (data_in==3) on a detect_add edge and holds otherwise. Reset 0.
- write_enb is combinational from the registered address: bit[addr] = write_enb_reg for addr 0..2. All bits are 0 for addr 3.
- fifo_full is combinational: full_n of the registered address. It is 0 when addr==3.
- vld_out_n = ~empty_n, combinational, independent of the address.
- Watchdog, one per port, each with a 6-bit counter cnt_n:
  - idle_n = vld_out_n & ~read_enb_n & ~soft_reset_n.
  - On an edge with idle_n=0: cnt_n <= 0 and soft_reset_n <= 0.
  - On an edge with idle_n=1 and cnt_n < TIMEOUT-1: cnt_n increments and soft_reset_n <= 0.
  - On an edge with idle_n=1 and cnt_n == TIMEOUT-1: soft_reset_n <= 1 and cnt_n <= 0.
  - soft_reset_n is therefore a one-cycle registered pulse. It cannot fire on two consecutive cycles.
- The three watchdogs run independently. Any number of them may fire on the same cycle.

## Timing
- Reset outputs: write_enb=3'b000, fifo_full=0, addr_err=0, soft_reset_n=0. vld_out_n follows empty_n. All counters are 0.
- Address latency is 1 cycle. A write_enb_reg asserted in the same cycle as detect_add uses the previously latched address. The FSM never writes in the detect_add cycle.
- A new detect_add mid-packet retargets write_enb from the next cycle; no protection is applied.
- Timeout latency: if idle_n holds through TIMEOUT consecutive edges, soft_reset_n is high for exactly the cycle after the TIMEOUT-th edge. Any read or empty in between restarts the count from 0.
- Counter arithmetic: 6-bit unsigned. It never exceeds TIMEOUT-1 and never wraps.
- The FIFO clears on the edge that samples soft_reset_n=1. empty_n then rises and the counter stays at 0.
- rst mid-operation clears every register on that edge, cancelling a pending or active soft reset.
- When rst and detect_add are high together, rst wins.

## Test plan
- Reset, then detect_add with data_in=1, then write_enb_reg=1 for 3 cycles -> write_enb=3'b010 for those 3 cycles, and 3'b000 before the address is latched.
- Address 2 latched, full_2=1, full_0=0 -> fifo_full=1. Then latch address 0 -> fifo_full=0 from the next cycle.
- detect_add with data_in=3, then write_enb_reg=1 -> write_enb=000, fifo_full=0, addr_err=1. Next detect_add with data_in=0 -> addr_err=0.
- empty_0=0 with read_enb_0=0 for 30 cycles (TIMEOUT=30) -> soft_reset_0 high for exactly 1 cycle after the 30th edge. A single read_enb_0 pulse at cycle 29 -> no soft reset, and the count restarts.
- Ports 1 and 2 idle-valid starting on the same cycle -> soft_reset_1 and soft_reset_2 pulse together. Port 0 stays empty -> soft_reset_0 stays 0.
- rst asserted at cycle 20 of a port 0 timeout -> no pulse at cycle 30. After rst drops, the count restarts from 0.
